regf_wb_arbiter: RTL and testbench

REGF_WB_ARBITER -- requirements
Module: regf_wb_arbiter

---
 rtl/regf_wb_arbiter_if.sv | 37 +++
 rtl/regf_wb_arbiter.sv | 121 ++++++++++++
 tb/tb_regf_wb_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/regf_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// regf_wb_arbiter_if
// Bundles the register-file writeback bus that regf_wb_arbiter sits on.
//   master : pipeline writeback stage + long-latency (aux) unit side
//   slave  : the arbiter itself
// Signals
//   pipe_we/pipe_rd_s/pipe_rd_v : pipeline write request, index, data
//   aux_valid/aux_rd_s/aux_rd_v : aux result offer, index, data
//   aux_ready                   : arbiter accepts the aux offer this cycle
//   aux_pending                 : at least one aux result buffered
//   pipe_stall                  : pipeline must hold its writeback stage
//   regf_we/rd_s/rd_v           : register file write port
// ---------------------------------------------------------------------------
interface regf_wb_arbiter_if;
  logic        pipe_we;
  logic [4:0]  pipe_rd_s;
  logic [31:0] pipe_rd_v;
  logic        aux_valid;
  logic [4:0]  aux_rd_s;
  logic [31:0] aux_rd_v;
  logic        aux_ready;
  logic        aux_pending;
  logic        pipe_stall;
  logic        regf_we;
  logic [4:0]  rd_s;
  logic [31:0] rd_v;

  modport master (
    output pipe_we, pipe_rd_s, pipe_rd_v, aux_valid, aux_rd_s, aux_rd_v,
    input  aux_ready, aux_pending, pipe_stall, regf_we, rd_s, rd_v
  );

  modport slave (
    input  pipe_we, pipe_rd_s, pipe_rd_v, aux_valid, aux_rd_s, aux_rd_v,
    output aux_ready, aux_pending, pipe_stall, regf_we, rd_s, rd_v
  );
endinterface

// File: rtl/regf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regf_wb_arbiter
// Shares one register-file write port between the pipeline writeback stage
// and a long-latency aux unit. Aux results are buffered in a 2-entry
// in-order FIFO and written in cycles the pipeline leaves the port free.
// With REGF_WB_ARB_STARVE_EN defined, a starvation counter forces a
// pipeline stall after STARVE_LIMIT consecutive denied cycles so the aux
// head is guaranteed to drain; otherwise pipe_stall is tied low.
// Ports
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : regf_wb_arbiter_if.slave (see interface file for signal list)
// Parameters
//   STARVE_LIMIT : denied cycles before stall, 1..15
// ---------------------------------------------------------------------------
module regf_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  regf_wb_arbiter_if.slave  bus
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("regf_wb_arbiter: STARVE_LIMIT must be in 1..15");
  end

  typedef struct packed {
    logic [4:0]  s;
    logic [31:0] v;
  } entry_t;

  entry_t      mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;

  logic        fifo_nonempty;
  logic        push;
  logic        pop;
  logic        stall;
  logic        grant_fifo;
  logic        grant_pipe;
  entry_t      head;

  assign fifo_nonempty = (count != 2'd0);
  assign head          = mem[rd_ptr];

  // No pass-through: a full FIFO refuses even if it pops this cycle.
  assign bus.aux_ready   = !rst && (count != 2'd2);
  assign bus.aux_pending = !rst && fifo_nonempty;
  assign push            = bus.aux_valid && bus.aux_ready;

`ifdef REGF_WB_ARB_STARVE_EN
  logic [3:0] starve_cnt;

  assign stall = !rst && fifo_nonempty && (starve_cnt == 4'(STARVE_LIMIT));

  // Counts cycles the buffered head is waiting; any pop or an empty FIFO
  // restarts the wait. It never passes STARVE_LIMIT because reaching it
  // forces the pop that clears it.
  always_ff @(posedge clk) begin
    if (rst || !fifo_nonempty || pop) begin
      starve_cnt <= 4'd0;
    end else begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  assign stall = 1'b0;
`endif

  assign bus.pipe_stall = stall;

  // NOTE: every output of this block gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    grant_fifo = 1'b0;
    grant_pipe = 1'b0;
    if (!rst) begin
      if (stall) begin
        grant_fifo = 1'b1;
      end else if (bus.pipe_we) begin
        grant_pipe = 1'b1;
      end else if (fifo_nonempty) begin
        grant_fifo = 1'b1;
      end
    end
  end

  assign pop         = grant_fifo;
  assign bus.rd_s    = grant_fifo ? head.s : bus.pipe_rd_s;
  assign bus.rd_v    = grant_fifo ? head.v : bus.pipe_rd_v;
  // x0 writes are swallowed; an x0 aux entry still pops.
  assign bus.regf_we = (grant_fifo || grant_pipe) && (bus.rd_s != 5'd0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is not reset; count/pointers gate every read,
  // so stale contents are never observed and the array stays plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{s: bus.aux_rd_s, v: bus.aux_rd_v};
  end

endmodule

// File: tb/tb_regf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regf_wb_arbiter
// Drives regf_wb_arbiter with directed scenarios and randomized traffic,
// comparing every cycle against a queue-based reference model of the
// arbitration rules. Honours REGF_WB_ARB_STARVE_EN the same way the RTL does.
// ---------------------------------------------------------------------------
module tb_regf_wb_arbiter;

  localparam int LIMIT = 4;
`ifdef REGF_WB_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  regf_wb_arbiter_if bus ();

  regf_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [4:0]  s;
    logic [31:0] v;
  } ent_t;

  ent_t  q[$];
  int    starve;
  int    n_total;
  int    n_bad;
  string phase;

  logic        obs_we, obs_ready, obs_pending, obs_stall;
  logic [4:0]  obs_s;
  logic [31:0] obs_v;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: got=%0h want=%0h", phase, tag, got, exp);
    end
  endtask

  function automatic bit model_stall();
    return STARVE_EN && (q.size() > 0) && (starve == LIMIT);
  endfunction

  // One clock cycle: apply inputs, predict, compare at negedge, advance model.
  task automatic step(input logic r, input logic pwe, input logic [4:0] ps,
                      input logic [31:0] pv, input logic av,
                      input logic [4:0] as, input logic [31:0] avv);
    logic        e_ready, e_pend, e_stall, e_we;
    logic [4:0]  e_s;
    logic [31:0] e_v;
    int          src;  // 0 none, 1 pipeline, 2 fifo head
    bit          was_nonempty;

    rst = r;
    bus.pipe_we = pwe; bus.pipe_rd_s = ps; bus.pipe_rd_v = pv;
    bus.aux_valid = av; bus.aux_rd_s = as; bus.aux_rd_v = avv;

    e_stall = !r && model_stall();
    e_ready = !r && (q.size() < 2);
    e_pend  = !r && (q.size() > 0);
    if (r)                src = 0;
    else if (e_stall)     src = 2;
    else if (pwe)         src = 1;
    else if (q.size() > 0) src = 2;
    else                  src = 0;
    e_s  = (src == 2) ? q[0].s : ps;
    e_v  = (src == 2) ? q[0].v : pv;
    e_we = (src != 0) && (e_s != 5'd0);

    @(negedge clk);
    obs_we = bus.regf_we; obs_s = bus.rd_s; obs_v = bus.rd_v;
    obs_ready = bus.aux_ready; obs_pending = bus.aux_pending; obs_stall = bus.pipe_stall;
    check("aux_ready",   obs_ready,   e_ready);
    check("aux_pending", obs_pending, e_pend);
    check("pipe_stall",  obs_stall,   e_stall);
    check("regf_we",     obs_we,      e_we);
    check("rd_s",        obs_s,       e_s);
    check("rd_v",        obs_v,       e_v);

    @(posedge clk);
    if (r) begin
      q.delete();
      starve = 0;
    end else begin
      was_nonempty = (q.size() > 0);
      if (src == 2) void'(q.pop_front());
      if (av && e_ready) q.push_back('{s: as, v: avv});
      starve = (src == 2 || !was_nonempty) ? 0 : starve + 1;
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    logic        pwe, av, r;
    logic [4:0]  ps, as;
    logic [31:0] pv, avv;

    n_total = 0; n_bad = 0; starve = 0;
    rst = 1'b1;
    bus.pipe_we = 1'b0; bus.pipe_rd_s = '0; bus.pipe_rd_v = '0;
    bus.aux_valid = 1'b0; bus.aux_rd_s = '0; bus.aux_rd_v = '0;
    @(posedge clk);
    #1;

    // Reset state and first cycle after reset.
    phase = "reset";
    do_reset();
    check("rst_ready", obs_ready, 1'b0);
    check("rst_we", obs_we, 1'b0);
    idle();
    check("post_ready", obs_ready, 1'b1);
    check("post_we", obs_we, 1'b0);

    // Single aux push to x5 with pipeline idle.
    phase = "aux_single";
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    idle();
    check("we_n1", obs_we, 1'b1);
    check("rd_s_n1", obs_s, 5'd5);
    check("rd_v_n1", obs_v, 32'hDEADBEEF);
    idle();
    check("pending_n2", obs_pending, 1'b0);

    // Busy pipeline, two aux pushes, drain in order once pipeline idles.
    phase = "aux_two";
    step(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd3, 32'h333);
    step(1'b0, 1'b1, 5'd1, 32'h12, 1'b1, 5'd4, 32'h444);
    step(1'b0, 1'b1, 5'd1, 32'h13, 1'b0, 5'd0, 32'd0);
    check("full_ready", obs_ready, 1'b0);
    check("pipe_wins", obs_s, 5'd1);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("first_s", obs_s, 5'd3);
    check("first_v", obs_v, 32'h333);
    idle();
    check("second_s", obs_s, 5'd4);
    check("second_v", obs_v, 32'h444);
    idle();
    check("drained", obs_pending, 1'b0);

    // Aux write to x0 is popped silently.
    phase = "aux_x0";
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hCAFE);
    idle();
    check("x0_we", obs_we, 1'b0);
    check("x0_pend", obs_pending, 1'b1);
    idle();
    check("x0_cleared", obs_pending, 1'b0);

    // Reset pulse with two buffered entries discards them.
    phase = "reset_mid";
    step(1'b0, 1'b1, 5'd2, 32'h22, 1'b1, 5'd6, 32'h666);
    step(1'b0, 1'b1, 5'd2, 32'h23, 1'b1, 5'd7, 32'h777);
    do_reset();
    idle();
    check("ready", obs_ready, 1'b1);
    check("pending", obs_pending, 1'b0);
    check("we", obs_we, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle();
      check("no_aux_we", obs_we, 1'b0);
    end

`ifdef REGF_WB_ARB_STARVE_EN
    // Starvation: stall on the 5th pending cycle, pipe write next cycle.
    phase = "starve";
    step(1'b0, 1'b1, 5'd7, 32'h7777, 1'b1, 5'd9, 32'h9999);
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 1'b1, 5'd7, 32'h7777, 1'b0, 5'd0, 32'd0);
      check("stall", obs_stall, (k == 5));
      check("src", obs_s, (k == 5) ? 5'd9 : 5'd7);
    end
    step(1'b0, 1'b1, 5'd7, 32'h7777, 1'b0, 5'd0, 32'd0);
    check("after_stall_s", obs_s, 5'd7);
    check("after_stall_we", obs_we, 1'b1);
    check("after_pend", obs_pending, 1'b0);
`else
    // No starvation logic: aux waits as long as the pipeline writes.
    phase = "no_starve";
    step(1'b0, 1'b1, 5'd7, 32'h7777, 1'b1, 5'd9, 32'h9999);
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b1, 5'd7, 32'h7777, 1'b0, 5'd0, 32'd0);
      check("stall", obs_stall, 1'b0);
      check("src", obs_s, 5'd7);
    end
    idle();
    check("aux_s", obs_s, 5'd9);
    check("aux_we", obs_we, 1'b1);
`endif

    // Randomized traffic against the model.
    phase = "random";
    pwe = 1'b0; ps = '0; pv = '0;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 99) < 2);
      if (!(model_stall() && !r)) begin
        pwe = ($urandom_range(0, 99) < 75);
        ps  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        pv  = $urandom;
      end
      av  = ($urandom_range(0, 99) < 50);
      as  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      avv = $urandom;
      step(r, pwe, ps, pv, av, as, avv);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
